// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Reusable pipeline stage register carrying a payload and a control bundle
//   across a valid/ready boundary through a two-entry skid buffer. Every
//   output is a flop output, and in_ready never depends combinationally on
//   out_ready.
//
// Parameters
//   DATA_W    payload width (>=1)
//   CTRL_W    control bundle width (>=1)
//   CNT_W     back-pressure counter width
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   flush      synchronous discard of all held entries (highest priority)
//   stall      hazard hold; gates the output handshake
//   in_valid   upstream entry present
//   in_ready   stage can accept (registered)
//   in_data    upstream payload
//   in_ctrl    upstream control bundle
//   out_valid  head entry present
//   out_ready  downstream can accept
//   out_data   head payload (holds last value on bubbles)
//   out_ctrl   head control, zero whenever out_valid is 0
//   occupancy  entries held: 0, 1 or 2
//   stall_cnt  saturating count of cycles with out_valid and no fire
module pipe_stage_skid #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [CNT_W-1:0]  cnt;

  logic accept;
  logic fire;

  // Outputs decode registered state only; no input reaches an output.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign stall_cnt = cnt;

  always_comb begin
    accept = in_valid & in_ready;
    fire   = out_valid & out_ready & ~stall;
  end

  // main_ctrl is cleared on every transition into EMPTY so that a bubble
  // always presents zero control without gating logic on the output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
      cnt       <= '0;
    end else begin
      if (out_valid && !fire && (cnt != '1))
        cnt <= cnt + 1'b1;

      if (flush) begin
        state     <= EMPTY;
        main_ctrl <= '0;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              main_data <= in_data;
              main_ctrl <= in_ctrl;
              state     <= ONE;
            end
          end
          ONE: begin
            if (accept && fire) begin
              main_data <= in_data;
              main_ctrl <= in_ctrl;
            end else if (accept) begin
              skid_data <= in_data;
              skid_ctrl <= in_ctrl;
              state     <= FULL;
            end else if (fire) begin
              main_ctrl <= '0;
              state     <= EMPTY;
            end
          end
          FULL: begin
            if (fire) begin
              main_data <= skid_data;
              main_ctrl <= skid_ctrl;
              state     <= ONE;
            end
          end
          default: begin
            main_ctrl <= '0;
            state     <= EMPTY;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int DW   = 16;
  localparam int CW   = 8;
  localparam int NW   = 4;
  localparam int CMAX = (1 << NW) - 1;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          stall;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .stall     (stall),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of held entries plus a saturating count.
  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t mq[$];
  int   mcnt = 0;

  initial begin : model
    int sz;
    bit f;
    bit a;
    ent_t e;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete();
        mcnt = 0;
      end else begin
        sz = mq.size();
        f  = (sz > 0) && out_ready && !stall;
        a  = in_valid && (sz < 2);
        if ((sz > 0) && !f && (mcnt < CMAX)) mcnt++;
        if (flush) begin
          mq.delete();
        end else begin
          if (f) e = mq.pop_front();
          if (a) begin
            e.d = in_data;
            e.c = in_ctrl;
            mq.push_back(e);
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        check("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
        check("occupancy", {30'd0, occupancy}, mq.size());
        check("in_ready", {31'd0, in_ready}, {31'd0, (mq.size() < 2)});
        check("stall_cnt", {28'd0, stall_cnt}, mcnt);
        if (mq.size() > 0) begin
          check("out_data", {16'd0, out_data}, {16'd0, mq[0].d});
          check("out_ctrl", {24'd0, out_ctrl}, {24'd0, mq[0].c});
        end else begin
          check("bubble_ctrl", {24'd0, out_ctrl}, 32'd0);
        end
      end
    end
  end

  task automatic idle_inputs();
    flush     = 1'b0;
    stall     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic offer(input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin : main
    rst = 1'b0;
    idle_inputs();
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_occupancy", {30'd0, occupancy}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    do_reset();

    // Streaming with downstream always ready.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      offer(DW'(i), 8'h01);
      @(negedge clk);
      check("stream_data", {16'd0, out_data}, i);
      check("stream_occ", {30'd0, occupancy}, 32'd1);
      check("stream_cnt", {28'd0, stall_cnt}, 32'd0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_empty", {30'd0, occupancy}, 32'd0);

    // Fill and drain.
    do_reset();
    out_ready = 1'b0;
    offer(16'hA, 8'h0A);
    @(negedge clk);
    offer(16'hB, 8'h0B);
    @(negedge clk);
    check("fill_occ", {30'd0, occupancy}, 32'd2);
    check("fill_in_ready", {31'd0, in_ready}, 32'd0);
    offer(16'hC, 8'h0C);
    @(negedge clk);
    @(negedge clk);
    check("fill_cnt", {28'd0, stall_cnt}, 32'd3);
    check("drain_a", {16'd0, out_data}, 32'hA);
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_b", {16'd0, out_data}, 32'hB);
    @(negedge clk);
    check("drain_c", {16'd0, out_data}, 32'hC);
    in_valid = 1'b0;
    @(negedge clk);
    check("drain_empty", {30'd0, occupancy}, 32'd0);
    check("drain_cnt", {28'd0, stall_cnt}, 32'd3);

    // Flush in FULL.
    do_reset();
    offer(16'h11, 8'h11);
    @(negedge clk);
    offer(16'h22, 8'h22);
    @(negedge clk);
    flush = 1'b1;
    stall = 1'b1;
    @(negedge clk);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_ctrl", {24'd0, out_ctrl}, 32'd0);
    check("flush_occ", {30'd0, occupancy}, 32'd0);
    check("flush_ready", {31'd0, in_ready}, 32'd1);
    flush = 1'b0;
    stall = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Stall gating.
    do_reset();
    out_ready = 1'b1;
    offer(16'h55, 8'hFF);
    @(negedge clk);
    in_valid = 1'b0;
    stall = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_cnt3", {28'd0, stall_cnt}, 32'd3);
    check("stall_hold", {24'd0, out_ctrl}, 32'hFF);
    stall = 1'b0;
    @(negedge clk);
    check("stall_release", {30'd0, occupancy}, 32'd0);
    check("stall_bubble", {24'd0, out_ctrl}, 32'd0);

    // Asynchronous reset while FULL.
    do_reset();
    offer(16'h31, 8'h31);
    @(negedge clk);
    offer(16'h32, 8'h32);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_ctrl", {24'd0, out_ctrl}, 32'd0);
    check("arst_data", {16'd0, out_data}, 32'd0);
    check("arst_occ", {30'd0, occupancy}, 32'd0);
    check("arst_ready", {31'd0, in_ready}, 32'd1);
    check("arst_cnt", {28'd0, stall_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    offer(16'h77, 8'h03);
    @(negedge clk);
    check("arst_first", {16'd0, out_data}, 32'h77);
    check("arst_first_occ", {30'd0, occupancy}, 32'd1);
    in_valid = 1'b0;

    // Counter saturation.
    do_reset();
    offer(16'h99, 8'h09);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("sat_cnt", {28'd0, stall_cnt}, 32'd15);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom);
      in_ctrl   = CW'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      if ((i % 500) == 250) begin
        do_reset();
      end else begin
        @(negedge clk);
      end
    end
    idle_inputs();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register that replaces per-signal stall-muxed flop banks between CPU stages with one reusable block. Carries a data payload and a control bundle across a valid/ready boundary through a two-entry skid buffer, so `in_ready` is a pure flop output and never combinationally depends on `out_ready`. Supports synchronous flush with guaranteed zeroed control on bubbles, plus a saturating back-pressure counter. Instantiated between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- `DATA_W`, default 64: payload width (pc, alu result, memory data, etc.); must be ≥1.
- `CTRL_W`, default 8: control bundle width (regWrite, halt, jump, …); must be ≥1.
- `CNT_W`, default 16: width of the stall counter.

- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-low reset.
- `flush`: input, 1 bit. Synchronous discard of all held entries.
- `stall`: input, 1 bit. Hazard-unit hold; gates the output handshake.
- `in_valid`: input, 1 bit. Upstream entry present.
- `in_ready`: output, 1 bit. Stage can accept; registered.
- `in_data`: input, `DATA_W` bits. Upstream payload.
- `in_ctrl`: input, `CTRL_W` bits. Upstream control bundle.
- `out_valid`: output, 1 bit. Head entry present.
- `out_ready`: input, 1 bit. Downstream can accept.
- `out_data`: output, `DATA_W` bits. Head payload.
- `out_ctrl`: output, `CTRL_W` bits. Head control; forced to 0 when `out_valid` is 0.
- `occupancy`: output, 2 bits. Entries held: 0, 1 or 2.
- `stall_cnt`: output, `CNT_W` bits. Saturating count of back-pressured cycles.

## Operation
- **Storage:** two entries, MAIN (head, drives outputs) and SKID. Each entry holds data, control and a valid bit.
- **Handshake terms:**
  - accept = `in_valid` & `in_ready`.
  - fire = `out_valid` & `out_ready` & ~`stall`.
- **States** (encoded as `occupancy`):
  - EMPTY (0):
    - accept: MAIN <= in, go to ONE.
    - otherwise: stay.
  - ONE (1):
    - accept & fire: MAIN <= in, stay.
    - accept & ~fire: SKID <= in, go to FULL.
    - ~accept & fire: go to EMPTY.
    - otherwise: hold.
  - FULL (2):
    - `in_ready` = 0.
    - fire: MAIN <= SKID, go to ONE.
    - otherwise: hold.
- **Ordering:** entries leave in arrival order. SKID is never presented ahead of MAIN.
- **in_ready:** equals 1 when state is not FULL, decoded from registered state only.
- **Flush:** has highest priority. Next state is EMPTY, and an accept in the flush cycle is dropped. Outputs during the flush cycle are unchanged, so a consumer firing in that cycle still takes the head. `stall_cnt` still updates normally in a flush cycle.
- **Bubble control:**
  - `out_ctrl` = 0 whenever `out_valid` = 0.
  - `out_data` keeps its last value (no toggling) and is don't-care for checking.
- **stall_cnt:**
  - Increments by 1 each cycle with `out_valid` & ~fire.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset.

## Timing
- **Reset** (`rst` low, asynchronous, takes effect immediately):
  - State goes to EMPTY.
  - `out_valid` = 0, `out_ctrl` = 0, `out_data` = 0, `occupancy` = 0, `stall_cnt` = 0.
  - `in_ready` = 1 while reset is held and after release.
  - Asserting reset mid-transfer discards both entries.
- **Latency:** an entry accepted at edge N is visible on `out_*` after edge N.
- **Throughput:** 1 entry per cycle when downstream is always ready.
- **Combinational paths:**
  - `out_*`, `in_ready` and `occupancy` are all flop outputs.
  - There is no combinational path from any input to any output.
- **Back-pressure:** `in_ready` falls one cycle after the stage fills. The skid entry absorbs the one in-flight accept.
- **Stall:** `stall` = 1 with `out_ready` = 1 behaves exactly like `out_ready` = 0.
- **Simultaneous events:**
  - Flush together with stall: flush wins.
  - Accept and fire in ONE: occupancy stays 1.
  - Fire in FULL: the SKID entry moves to MAIN in the same edge.

## Test plan
- **Streaming:** hold `out_ready` = 1 and send data 0x1..0x8 with ctrl 0x01 on consecutive cycles. `out_data` shows 0x1..0x8 one cycle later, back to back. `occupancy` stays 1 and `stall_cnt` stays 0.
- **Fill and drain:** hold `out_ready` = 0 and offer 0xA, 0xB, 0xC. 0xA and 0xB are accepted, `in_ready` = 0 after the second accept, and 0xC is held upstream. Then raise `out_ready`: outputs are 0xA, 0xB, 0xC in order, and `stall_cnt` equals the number of blocked cycles.
- **Flush in FULL:** from the FULL state pulse `flush` for one cycle. The next cycle shows `out_valid` = 0, `out_ctrl` = 0, `occupancy` = 0 and `in_ready` = 1. Neither flushed entry ever appears.
- **Stall gating:** with `out_ready` = 1, `stall` = 1 for 3 cycles and the head holding ctrl 0xFF. The head is held (no fire) and `stall_cnt` increases by 3. Dropping `stall` releases the entry.
- **Asynchronous reset mid-operation:** with the stage in FULL, drive `rst` low between clock edges. Outputs go to 0 and `occupancy` goes to 0 immediately, without waiting for a clock edge. After release, the first accept appears one cycle later.
- **Counter saturation:** with `CNT_W` = 4, block the output for 20 cycles. `stall_cnt` stops at 15 and does not wrap.
